// File: rtl/mpt_pkg.sv
// MPT walker shared types: table entry layout, walk result codes and the
// transaction bundle passed between walker pipeline stages.
package mpt_pkg;

  localparam int MPT_IDX_WIDTH   = 9;
  localparam int MPT_PAGE_OFFSET = 12;
  localparam int MPT_PPN_WIDTH   = 44;
  localparam int MPT_SPA_WIDTH   = 56;
  localparam int MPT_ENTRY_W     = 64;

  typedef enum logic [1:0] {
    ALLOW         = 2'd0,
    FAULT_INVALID = 2'd1,
    FAULT_PERM    = 2'd2
  } mpt_result_e;

  typedef enum logic {
    MPT_WALKING_SKIP = 1'b0,
    MPT_WALKING_DO   = 1'b1
  } mpt_walking_e;

  typedef enum logic [1:0] {
    ACCESS_READ  = 2'd0,
    ACCESS_WRITE = 2'd1,
    ACCESS_EXEC  = 2'd2
  } mpt_access_e;

  typedef struct packed {
    logic [MPT_PPN_WIDTH-1:0] ppn;
  } mmpt_t;

  typedef struct packed {
    logic [9:0]               rsvd_hi;
    logic [MPT_PPN_WIDTH-1:0] ppn;
    logic [4:0]               rsvd_lo;
    logic                     x;
    logic                     w;
    logic                     r;
    logic                     l;
    logic                     v;
  } mpt_entry_t;

  typedef struct packed {
    mpt_walking_e             walking;
    mpt_access_e              access;
    mpt_result_e              result;
    mmpt_t                    mmpt;
    logic [MPT_SPA_WIDTH-1:0] spa;
  } mptw_transaction_t;

  function automatic logic mpt_perm_ok(input mpt_entry_t e,
                                       input mpt_access_e a);
    logic ok;
    ok = 1'b0;
    unique case (a)
      ACCESS_READ:  ok = e.r;
      ACCESS_WRITE: ok = e.w;
      ACCESS_EXEC:  ok = e.x;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mpt_entry_check.sv
// Combinational decode of one MPT entry for the current walk level.
// Ports: entry_i/access_i/level_i in; done_o (stop walking), result_o, ppn_o.
module mpt_entry_check
  import mpt_pkg::*;
#(
  parameter int MPT_LEVELS = 3,
  parameter int LVL_W      = 2
) (
  input  mpt_entry_t               entry_i,
  input  mpt_access_e              access_i,
  input  logic [LVL_W-1:0]         level_i,
  output logic                     done_o,
  output mpt_result_e              result_o,
  output logic [MPT_PPN_WIDTH-1:0] ppn_o
);

  logic last;
  logic unused_rsvd;

  assign last        = (level_i == LVL_W'(MPT_LEVELS - 1));
  assign unused_rsvd = ^{entry_i.rsvd_hi, entry_i.rsvd_lo};
  assign ppn_o       = entry_i.ppn;

  always_comb begin
    done_o   = 1'b1;
    result_o = FAULT_INVALID;
    // W without R is a reserved encoding, checked before the leaf test
    if (!entry_i.v || (entry_i.w && !entry_i.r)) begin
      result_o = FAULT_INVALID;
    end else if (entry_i.l) begin
      result_o = mpt_perm_ok(entry_i, access_i) ? ALLOW : FAULT_PERM;
    end else if (last) begin
      result_o = FAULT_INVALID;
    end else begin
      done_o = 1'b0;
    end
  end

endmodule

// File: rtl/mpt_walk_stage.sv
// MPT walk stage: forwards SKIP transactions, walks the table for DO ones.
// Ports: clk_i/rst_i, slave/master valid-ready data ports, ctrl stall/flush,
// single-outstanding table read port. MPT_WALK_PERF_EN adds perf counters.
module mpt_walk_stage
  import mpt_pkg::*;
#(
  parameter int PIPELINE_SLAVE_DATA_WIDTH  = 32,
  parameter int PIPELINE_MASTER_DATA_WIDTH = 32,
  parameter int MPT_LEVELS                 = 3,
  parameter int MEM_ADDR_WIDTH             = 56,
  parameter int MEM_DATA_WIDTH             = 64
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]  mpt_walk_slave_data,
  input  logic                                  mpt_walk_slave_valid,
  output logic                                  mpt_walk_slave_ready,
  output logic [PIPELINE_MASTER_DATA_WIDTH-1:0] mpt_walk_master_data,
  output logic                                  mpt_walk_master_valid,
  input  logic                                  mpt_walk_master_ready,
  input  logic                                  mpt_walk_ctrl_stall,
  input  logic                                  mpt_walk_ctrl_flush,
  output logic                                  mpt_mem_req,
  input  logic                                  mpt_mem_gnt,
  output logic [MEM_ADDR_WIDTH-1:0]             mpt_mem_addr,
  output logic                                  mpt_mem_we,
  output logic [MEM_DATA_WIDTH-1:0]             mpt_mem_wdata,
  output logic [MEM_DATA_WIDTH/8-1:0]           mpt_mem_be,
  input  logic                                  mpt_mem_valid,
  input  logic [MEM_DATA_WIDTH-1:0]             mpt_mem_rdata
`ifdef MPT_WALK_PERF_EN
  ,
  output logic [31:0]                           mpt_walk_perf_walks_o,
  output logic [31:0]                           mpt_walk_perf_reads_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int LVL_W  = (MPT_LEVELS > 1) ? $clog2(MPT_LEVELS) : 1;
  localparam int TXN_W  = $bits(mptw_transaction_t);
  localparam int IN_W   = (PIPELINE_SLAVE_DATA_WIDTH > TXN_W) ?
                          PIPELINE_SLAVE_DATA_WIDTH : TXN_W;
  localparam int OUT_W  = (PIPELINE_MASTER_DATA_WIDTH > TXN_W) ?
                          PIPELINE_MASTER_DATA_WIDTH : TXN_W;

  state_e                   state_q, state_d;
  mptw_transaction_t        txn_q, txn_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic [MPT_PPN_WIDTH-1:0] base_q, base_d;

  mptw_transaction_t        in_txn;
  logic [IN_W-1:0]          in_w;
  logic [OUT_W-1:0]         out_w;
  logic                     unused_bus;
  logic                     accept;
  logic                     grant;
  logic [MPT_IDX_WIDTH-1:0] idx;
  int unsigned              idx_sh;

  mpt_entry_t               entry;
  logic                     chk_done;
  mpt_result_e              chk_result;
  logic [MPT_PPN_WIDTH-1:0] chk_ppn;

  // Bus widths may differ from the bundle; pad or truncate at the edges.
  assign in_w       = IN_W'(mpt_walk_slave_data);
  assign in_txn     = mptw_transaction_t'(in_w[TXN_W-1:0]);
  assign out_w      = OUT_W'(txn_q);
  assign unused_bus = ^{in_w, out_w};

  assign mpt_walk_master_data  = out_w[PIPELINE_MASTER_DATA_WIDTH-1:0];
  assign mpt_walk_master_valid = (state_q == S_DONE) && !rst_i;
  assign mpt_walk_slave_ready  = (state_q == S_IDLE) &&
                                 !mpt_walk_ctrl_stall && !rst_i;
  assign accept = mpt_walk_slave_valid && mpt_walk_slave_ready;

  assign mpt_mem_req   = (state_q == S_REQ) && !mpt_walk_ctrl_stall && !rst_i;
  assign grant         = mpt_mem_req && mpt_mem_gnt;
  assign mpt_mem_we    = 1'b0;
  assign mpt_mem_wdata = '0;
  assign mpt_mem_be    = {(MEM_DATA_WIDTH/8){1'b1}};

  // Level 0 uses the most significant index slice of the address.
  always_comb begin
    idx_sh = MPT_PAGE_OFFSET +
             MPT_IDX_WIDTH * (MPT_LEVELS - 1 - int'(level_q));
    idx    = MPT_IDX_WIDTH'(txn_q.spa >> idx_sh);
  end

  // Address is a pure function of held state, so it is stable across stalls.
  assign mpt_mem_addr = (state_q == S_REQ) ?
                        MEM_ADDR_WIDTH'({base_q, idx, 3'b000}) : '0;

  assign entry = mpt_entry_t'(MPT_ENTRY_W'(mpt_mem_rdata));

  mpt_entry_check #(
    .MPT_LEVELS(MPT_LEVELS),
    .LVL_W     (LVL_W)
  ) u_check (
    .entry_i (entry),
    .access_i(txn_q.access),
    .level_i (level_q),
    .done_o  (chk_done),
    .result_o(chk_result),
    .ppn_o   (chk_ppn)
  );

  always_comb begin
    state_d = state_q;
    txn_d   = txn_q;
    level_d = level_q;
    base_d  = base_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && !mpt_walk_ctrl_flush) begin
          txn_d = in_txn;
          if (in_txn.walking == MPT_WALKING_SKIP) begin
            txn_d.result = ALLOW;
            state_d      = S_DONE;
          end else begin
            level_d = '0;
            base_d  = in_txn.mmpt.ppn;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mpt_walk_ctrl_flush) begin
          state_d = grant ? S_DRAIN : S_IDLE;
        end else if (grant) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response coinciding with flush is the one we would drain.
        if (mpt_walk_ctrl_flush) begin
          state_d = mpt_mem_valid ? S_IDLE : S_DRAIN;
        end else if (mpt_mem_valid) begin
          if (chk_done) begin
            txn_d.result = chk_result;
            state_d      = S_DONE;
          end else begin
            base_d  = chk_ppn;
            level_d = level_q + LVL_W'(1);
            state_d = S_REQ;
          end
        end
      end
      S_DRAIN: begin
        if (mpt_mem_valid) state_d = S_IDLE;
      end
      S_DONE: begin
        if (mpt_walk_ctrl_flush || mpt_walk_master_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      txn_q   <= '0;
      level_q <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      level_q <= level_d;
      base_q  <= base_d;
    end
  end

`ifdef MPT_WALK_PERF_EN
  logic        walk_done;
  logic [31:0] walks_q;
  logic [31:0] reads_q;

  assign walk_done = (state_q == S_WAIT) && !mpt_walk_ctrl_flush &&
                     mpt_mem_valid && chk_done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      walks_q <= '0;
      reads_q <= '0;
    end else begin
      if (walk_done) walks_q <= walks_q + 32'd1;
      if (grant)     reads_q <= reads_q + 32'd1;
    end
  end

  assign mpt_walk_perf_walks_o = walks_q;
  assign mpt_walk_perf_reads_o = reads_q;
`endif

endmodule

// File: tb/tb_mpt_walk_stage.sv
// Directed bench for mpt_walk_stage with a simple table memory model.
module tb_mpt_walk_stage;
  import mpt_pkg::*;

  localparam int TW = $bits(mptw_transaction_t);

  logic          clk;
  logic          rst;
  logic [TW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [TW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          stall;
  logic          flush;
  logic          mem_req;
  logic          mem_gnt;
  logic [55:0]   mem_addr;
  logic          mem_we;
  logic [63:0]   mem_wdata;
  logic [7:0]    mem_be;
  logic          mem_valid;
  logic [63:0]   mem_rdata;
`ifdef MPT_WALK_PERF_EN
  logic [31:0]   perf_walks;
  logic [31:0]   perf_reads;
`endif

  mpt_walk_stage #(
    .PIPELINE_SLAVE_DATA_WIDTH (TW),
    .PIPELINE_MASTER_DATA_WIDTH(TW),
    .MPT_LEVELS                (3),
    .MEM_ADDR_WIDTH            (56),
    .MEM_DATA_WIDTH            (64)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .mpt_walk_slave_data  (s_data),
    .mpt_walk_slave_valid (s_valid),
    .mpt_walk_slave_ready (s_ready),
    .mpt_walk_master_data (m_data),
    .mpt_walk_master_valid(m_valid),
    .mpt_walk_master_ready(m_ready),
    .mpt_walk_ctrl_stall  (stall),
    .mpt_walk_ctrl_flush  (flush),
    .mpt_mem_req          (mem_req),
    .mpt_mem_gnt          (mem_gnt),
    .mpt_mem_addr         (mem_addr),
    .mpt_mem_we           (mem_we),
    .mpt_mem_wdata        (mem_wdata),
    .mpt_mem_be           (mem_be),
    .mpt_mem_valid        (mem_valid),
    .mpt_mem_rdata        (mem_rdata)
`ifdef MPT_WALK_PERF_EN
    ,
    .mpt_walk_perf_walks_o(perf_walks),
    .mpt_walk_perf_reads_o(perf_reads)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // memory model
  logic [63:0] mem [logic [55:0]];
  int          gnt_delay = 0;
  int          resp_delay = 1;
  int          gwait = 0;
  bit          pend = 0;
  int          rcnt = 0;
  logic [63:0] rdata_q = '0;
  int          ngnt = 0;
  int          nreq = 0;
  int          nmv = 0;
  logic [55:0] gq [$];

  assign mem_gnt   = mem_req && (gwait >= gnt_delay);
  assign mem_valid = pend && (rcnt == 0);
  assign mem_rdata = mem_valid ? rdata_q : 64'h0;

  always @(posedge clk) begin
    if (rst) begin
      gwait <= 0;
      pend  <= 0;
      rcnt  <= 0;
    end else if (mem_req && mem_gnt) begin
      gwait   <= 0;
      pend    <= 1;
      rcnt    <= resp_delay - 1;
      rdata_q <= mem.exists(mem_addr) ? mem[mem_addr] : 64'h0;
      ngnt    <= ngnt + 1;
      gq.push_back(mem_addr);
    end else begin
      if (mem_req) gwait <= gwait + 1;
      if (pend) begin
        if (rcnt == 0) pend <= 0;
        else rcnt <= rcnt - 1;
      end
    end
    if (mem_req) nreq <= nreq + 1;
    if (m_valid) nmv <= nmv + 1;
  end

  function automatic logic [63:0] mk_entry(input logic [43:0] ppn,
                                           input logic [4:0] fl);
    return {10'b0, ppn, 5'b0, fl};
  endfunction

  function automatic logic [55:0] mk_addr(input logic [43:0] b,
                                          input logic [8:0] i);
    return {b, i, 3'b000};
  endfunction

  function automatic logic [55:0] mk_spa(input logic [8:0] i0,
                                         input logic [8:0] i1,
                                         input logic [8:0] i2);
    return {17'b0, i0, i1, i2, 12'h345};
  endfunction

  function automatic mptw_transaction_t mk_txn(input mpt_walking_e wk,
                                               input mpt_access_e ac,
                                               input logic [43:0] root,
                                               input logic [55:0] spa);
    mptw_transaction_t t;
    t          = '0;
    t.walking  = wk;
    t.access   = ac;
    t.result   = mpt_result_e'(2'd3);
    t.mmpt.ppn = root;
    t.spa      = spa;
    return t;
  endfunction

  task automatic run(input string tag, input mptw_transaction_t t,
                     input mpt_result_e res, input int exp_lat,
                     input int exp_reads);
    mptw_transaction_t e;
    int g0, r0, lat, k;
    e        = t;
    e.result = res;
    g0       = ngnt;
    r0       = nreq;
    m_ready  = 1'b1;
    s_data   = t;
    s_valid  = 1'b1;
    k = 0;
    while (!s_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check({tag, "_rdy"}, s_ready, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    lat = 1;
    while (!m_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, m_data, e);
    @(posedge clk); #1;
    check({tag, "_vlow"}, m_valid, 1'b0);
    check({tag, "_reads"}, ngnt - g0, exp_reads);
    if (exp_reads == 0) check({tag, "_noreq"}, nreq - r0, 0);
  endtask

  function automatic logic [55:0] gq_at(input int i);
    return (gq.size() > i) ? gq[i] : '1;
  endfunction

  mptw_transaction_t tx, ex;
  int g0, n0, c;

  initial begin
    rst = 1'b1; s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
    stall = 1'b0; flush = 1'b0;

    mem[mk_addr(44'h100, 9'h011)] = mk_entry(44'h200, 5'b00001);
    mem[mk_addr(44'h200, 9'h022)] = mk_entry(44'h300, 5'b00001);
    mem[mk_addr(44'h300, 9'h033)] = mk_entry(44'h777, 5'b00111);
    mem[mk_addr(44'h400, 9'h044)] = mk_entry(44'h777, 5'b00111);
    mem[mk_addr(44'h500, 9'h055)] = mk_entry(44'h600, 5'b00001);
    mem[mk_addr(44'h600, 9'h066)] = mk_entry(44'h700, 5'b00001);
    mem[mk_addr(44'h700, 9'h077)] = mk_entry(44'h800, 5'b00001);
    mem[mk_addr(44'h800, 9'h012)] = mk_entry(44'h900, 5'b00001);
    mem[mk_addr(44'hC00, 9'h0AB)] = mk_entry(44'h111, 5'b10011);
    mem[mk_addr(44'hD00, 9'h0CD)] = mk_entry(44'h111, 5'b01011);
    mem[mk_addr(44'hE00, 9'h001)] = mk_entry(44'hF00, 5'b00001);
    mem[mk_addr(44'hF00, 9'h002)] = mk_entry(44'h111, 5'b01111);
    mem[mk_addr(44'hB00, 9'h1F0)] = mk_entry(44'h123, 5'b00111);

    @(posedge clk); #1;
    check("rst_sready", s_ready, 1'b0);
    check("rst_mvalid", m_valid, 1'b0);
    check("rst_mdata", m_data, '0);
    check("rst_req", mem_req, 1'b0);
    check("rst_addr", mem_addr, '0);
    check("rst_we", mem_we, 1'b0);
    check("rst_wdata", mem_wdata, '0);
    check("rst_be", mem_be, 8'hFF);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_sready", s_ready, 1'b1);
    @(posedge clk); #1;

    run("skip", mk_txn(MPT_WALKING_SKIP, ACCESS_WRITE, 44'h100,
                       mk_spa(9'h011, 9'h022, 9'h033)), ALLOW, 1, 0);

    gq.delete();
    run("w3lvl", mk_txn(MPT_WALKING_DO, ACCESS_READ, 44'h100,
                        mk_spa(9'h011, 9'h022, 9'h033)), ALLOW, 7, 3);
    check("w3lvl_a0", gq_at(0), mk_addr(44'h100, 9'h011));
    check("w3lvl_a1", gq_at(1), mk_addr(44'h200, 9'h022));
    check("w3lvl_a2", gq_at(2), mk_addr(44'h300, 9'h033));

    run("wperm", mk_txn(MPT_WALKING_DO, ACCESS_WRITE, 44'h400,
                        mk_spa(9'h044, 9'h0, 9'h0)), FAULT_PERM, 3, 1);
    run("nonleaf", mk_txn(MPT_WALKING_DO, ACCESS_READ, 44'h500,
                          mk_spa(9'h055, 9'h066, 9'h077)),
        FAULT_INVALID, 7, 3);
    run("inval", mk_txn(MPT_WALKING_DO, ACCESS_READ, 44'h800,
                        mk_spa(9'h012, 9'h034, 9'h056)),
        FAULT_INVALID, 5, 2);
    run("exec", mk_txn(MPT_WALKING_DO, ACCESS_EXEC, 44'hC00,
                       mk_spa(9'h0AB, 9'h0, 9'h0)), ALLOW, 3, 1);
    run("wnor", mk_txn(MPT_WALKING_DO, ACCESS_WRITE, 44'hD00,
                       mk_spa(9'h0CD, 9'h0, 9'h0)), FAULT_INVALID, 3, 1);
    run("wlvl1", mk_txn(MPT_WALKING_DO, ACCESS_WRITE, 44'hE00,
                        mk_spa(9'h001, 9'h002, 9'h003)), ALLOW, 5, 2);

    // flush while waiting for a slow response
    resp_delay = 4;
    n0 = nmv;
    s_data  = mk_txn(MPT_WALKING_DO, ACCESS_READ, 44'hA00,
                     mk_spa(9'h00A, 9'h0, 9'h0));
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    check("fl_req", mem_req, 1'b1);
    @(posedge clk); #1;
    flush = 1'b1;
    check("fl_wait_rdy", s_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_drain_rdy0", s_ready, 1'b0);
    @(posedge clk); #1;
    check("fl_drain_rdy1", s_ready, 1'b0);
    @(posedge clk); #1;
    check("fl_resp", mem_valid, 1'b1);
    check("fl_drain_rdy2", s_ready, 1'b0);
    @(posedge clk); #1;
    check("fl_idle_rdy", s_ready, 1'b1);
    check("fl_no_out", nmv - n0, 0);
    resp_delay = 1;

    run("skip2", mk_txn(MPT_WALKING_SKIP, ACCESS_EXEC, 44'h0,
                        mk_spa(9'h1, 9'h2, 9'h3)), ALLOW, 1, 0);

    // delayed grant with stall pulses, backpressured output
    gnt_delay  = 4;
    resp_delay = 2;
    g0 = ngnt;
    tx = mk_txn(MPT_WALKING_DO, ACCESS_READ, 44'hB00,
                mk_spa(9'h1F0, 9'h0, 9'h0));
    ex = tx;
    ex.result = ALLOW;
    m_ready = 1'b0;
    s_data  = tx;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    c = 0;
    while (ngnt == g0 && c < 12) begin
      stall = (c == 1 || c == 2 || c == 5);
      #1;
      check("st_addr", mem_addr, mk_addr(44'hB00, 9'h1F0));
      check("st_req", mem_req, !stall);
      @(posedge clk); #1;
      c++;
    end
    check("st_gnt", ngnt - g0, 1);
    check("st_cycles", c, 8);
    stall = 1'b1;
    c = 0;
    while (!m_valid && c < 20) begin
      @(posedge clk); #1; c++;
    end
    check("st_resp_cyc", c, 2);
    for (int i = 0; i < 5; i++) begin
      check("st_hold_v", m_valid, 1'b1);
      check("st_hold_d", m_data, ex);
      @(posedge clk); #1;
    end
    stall   = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    check("st_release", m_valid, 1'b0);
    gnt_delay  = 0;
    resp_delay = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpt_walk_stage.md
# mpt_walk_stage

- Pipeline stage directly downstream of the PLB lookup stage in the MPT walker.
- Consumes `mptw_transaction_t` transactions already tagged `MPT_WALKING_SKIP` / `MPT_WALKING_DO`:
  - `MPT_WALKING_SKIP`: forwarded without memory traffic, result ALLOW.
  - `MPT_WALKING_DO`: walks the multi-level memory protection table through a MEM/SRAM read port, one outstanding access at a time, and checks leaf permissions.
- Emits the transaction with its `result` field set to the next pipeline register.

## Interface
Parameters:
- `PIPELINE_SLAVE_DATA_WIDTH`, 32: width of input transaction bus (≥ `$bits(mptw_transaction_t)`).
- `PIPELINE_MASTER_DATA_WIDTH`, 32: width of output transaction bus.
- `MPT_LEVELS`, 3: table levels walked (1..4).
- `MEM_ADDR_WIDTH`, 56: physical address width of table reads.
- `MEM_DATA_WIDTH`, 64: table entry width.

Ports:
- Clock and reset:
  - `clk_i` in 1: single clock.
  - `rst_i` in 1: synchronous, active-high reset.
- Slave data port:
  - `mpt_walk_slave_data` in `PIPELINE_SLAVE_DATA_WIDTH`: incoming transaction.
  - `mpt_walk_slave_valid` in 1 / `mpt_walk_slave_ready` out 1: input handshake.
- Master data port:
  - `mpt_walk_master_data` out `PIPELINE_MASTER_DATA_WIDTH`: transaction with `result` set.
  - `mpt_walk_master_valid` out 1 / `mpt_walk_master_ready` in 1: output handshake.
- Control port:
  - `mpt_walk_ctrl_stall` in 1: stall.
  - `mpt_walk_ctrl_flush` in 1: flush.
- Table memory port:
  - `mpt_mem_req` out 1: read request.
  - `mpt_mem_gnt` in 1: request accepted.
  - `mpt_mem_addr` out `MEM_ADDR_WIDTH`: entry address.
  - `mpt_mem_we` out 1: always 0.
  - `mpt_mem_wdata` out `MEM_DATA_WIDTH`: always 0.
  - `mpt_mem_be` out `MEM_DATA_WIDTH/8`: always all-ones.
  - `mpt_mem_valid` in 1: read data valid.
  - `mpt_mem_rdata` in `MEM_DATA_WIDTH`: entry data.

## Operation
FSM states: IDLE, REQ, WAIT, DRAIN, DONE.

- IDLE:
  - `slave_ready` = ~stall. Transaction captured on valid&&ready.
  - SKIP: result=ALLOW, go to DONE.
  - DO: level=0, base=`mmpt.ppn`, go to REQ.
- REQ:
  - `mem_req`=1 unless stall.
  - Address = {base, idx(level), 3'b000}, where idx(level) = `spa[12+9*(MPT_LEVELS-1-level) +: 9]`.
  - On gnt, go to WAIT.
  - Address is held stable while waiting for gnt.
- WAIT:
  - On `mem_valid`, decode the entry. Fields: V=bit0, L=bit1, R=bit2, W=bit3, X=bit4, PPN=bits[53:10].
  - !V, or W&&!R: result FAULT_INVALID, go to DONE.
  - L: permission check (READ needs R, WRITE needs W, EXEC needs X). Result ALLOW or FAULT_PERM, go to DONE.
  - !L and level==MPT_LEVELS-1: FAULT_INVALID, go to DONE.
  - Otherwise: base=PPN, level++, go to REQ.
- DONE:
  - `master_valid`=1; data held stable until `master_ready`.
  - On handshake, go to IDLE. No new input is accepted in the same cycle.
- Stall:
  - Blocks accept in IDLE and req issue in REQ.
  - Never blocks response capture in WAIT. A response arriving during stall is registered.
- Flush:
  - From IDLE, REQ (no gnt this cycle) or DONE: go to IDLE and drop the transaction.
  - From WAIT, or REQ with gnt this cycle: go to DRAIN. DRAIN discards the single outstanding response, then goes to IDLE.
  - Flush has priority over every other transition.
- Level counter width: `$clog2(MPT_LEVELS)` (min 1). It never exceeds MPT_LEVELS-1.

## Timing
- Reset values:
  - FSM in IDLE.
  - `slave_ready`=0 during the reset cycle, 1 afterwards.
  - `master_valid`=0, `master_data`=0.
  - `mem_req`=0, `mem_addr`=0, `mem_we`=0, `mem_wdata`=0, `mem_be`=all-ones.
- Reset mid-walk: return to IDLE. The memory shares the reset domain; no response is expected afterwards.
- Skip latency: accepted in cycle N, `master_valid` in N+1.
- Walk latency with zero-wait memory (gnt with req, valid one cycle after gnt): `master_valid` at N+1+2·(levels read).
- At most one request outstanding. A new req is never issued before the previous `mem_valid`.
- Memory contract: `mem_valid` is never concurrent with the gnt of the same request.

## Configuration
- Macro: `MPT_WALK_PERF_EN`.
- Defined: adds two output ports, both reset to 0, incremented on the event, wrapping at 2^32:
  - `mpt_walk_perf_walks_o` (32): completed DO walks.
  - `mpt_walk_perf_reads_o` (32): granted reads.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- `mpt_pkg` holds:
  - `mpt_entry_t` bitfields.
  - `mpt_result_e` (ALLOW, FAULT_INVALID, FAULT_PERM).
  - `result` field added to `mptw_transaction_t`.
  - `MPT_IDX_WIDTH`=9, `MPT_PAGE_OFFSET`=12.
- FSM state enum is local to the module.
- One sub-module, `mpt_entry_check`: combinational decode of the entry plus access type and level, giving next-action and result.

## Test plan
- SKIP transaction, master_ready=1 -> `master_valid` one cycle after accept, result ALLOW, no `mem_req`.
- DO, READ, 3 levels, leaf at level 2 with R=1, zero-wait memory -> reads at {root,idx2,000}, {ppn1,idx1,000}, {ppn2,idx0,000}; ALLOW at N+7.
- DO, WRITE, leaf at level 0 with R=1, W=0 -> one read, FAULT_PERM at N+3.
- Non-leaf entry at level 2 -> FAULT_INVALID after 3 reads. Entry with V=0 at level 1 -> FAULT_INVALID after 2 reads.
- Flush in WAIT; response arrives 3 cycles later -> response discarded, `slave_ready` high the cycle after DRAIN consumes it, no output.
- gnt delayed 4 cycles with stall pulses and master_ready low for 5 cycles -> `mem_addr` and `master_data` held stable; result correct.
